// File: rtl/uart_rx_cmd_decoder.sv
// uart_rx_cmd_decoder: assembles UART bytes into command frames and issues register-file / ALU strobes
// Ports: clk, rst_n (sync active-low); rx_data/rx_valid/par_err/stp_err from the UART receiver;
// rf_wr_en/rf_rd_en/rf_addr/rf_wr_data to the register file; alu_en/alu_fun/op_a/op_b to the ALU;
// frame_err pulses on an aborted frame; busy is high outside IDLE.
// Optional: define FRAME_TIMEOUT_EN to abort frames that stall longer than TIMEOUT cycles between bytes.
module uart_rx_cmd_decoder #(
    parameter int         ADDR_W      = 4,
    parameter logic [7:0] CMD_RF_WR   = 8'hAA,
    parameter logic [7:0] CMD_RF_RD   = 8'hBB,
    parameter logic [7:0] CMD_ALU_OP  = 8'hCC,
    parameter logic [7:0] CMD_ALU_NOP = 8'hDD,
    parameter int         TIMEOUT     = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              par_err,
    input  logic              stp_err,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [7:0]        rf_wr_data,
    output logic              alu_en,
    output logic [3:0]        alu_fun,
    output logic [7:0]        op_a,
    output logic [7:0]        op_b,
    output logic              frame_err,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN, NOP_FUN} state_t;

    if (ADDR_W < 1 || ADDR_W > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("uart_rx_cmd_decoder: unsupported ADDR_W/TIMEOUT");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [7:0]        rf_wr_data_q, rf_wr_data_d;
    logic [3:0]        alu_fun_q, alu_fun_d;
    logic [7:0]        op_a_q, op_a_d;
    logic [7:0]        op_b_q, op_b_d;
    logic              rf_wr_en_q, rf_wr_en_d;
    logic              rf_rd_en_q, rf_rd_en_d;
    logic              alu_en_q, alu_en_d;
    logic              frame_err_q, frame_err_d;
    logic              bad, addr_ok, fun_ok;

    assign bad     = par_err || stp_err;
    assign addr_ok = (rx_data >> ADDR_W) == 8'd0;
    assign fun_ok  = rx_data[7:4] == 4'd0;

`ifdef FRAME_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo;
    // cnt_q holds the silent cycles before the current one, so expiry lands on the TIMEOUT-th silent cycle
    assign cnt_d = (state_q == IDLE || rx_valid) ? '0 : cnt_q + 1'b1;
    assign tmo   = state_q != IDLE && !rx_valid && cnt_q == CW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        state_d      = state_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        alu_fun_d    = alu_fun_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_en_d     = 1'b0;
        frame_err_d  = 1'b0;
        if (rx_valid && bad) begin
            state_d     = IDLE;
            frame_err_d = state_q != IDLE;
        end else if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    state_d     = rx_data == CMD_RF_WR   ? WR_ADDR :
                                  rx_data == CMD_RF_RD   ? RD_ADDR :
                                  rx_data == CMD_ALU_OP  ? ALU_A   :
                                  rx_data == CMD_ALU_NOP ? NOP_FUN : IDLE;
                    frame_err_d = rx_data != CMD_RF_WR && rx_data != CMD_RF_RD &&
                                  rx_data != CMD_ALU_OP && rx_data != CMD_ALU_NOP;
                end
                WR_ADDR, RD_ADDR: begin
                    state_d     = (addr_ok && state_q == WR_ADDR) ? WR_DATA : IDLE;
                    frame_err_d = !addr_ok;
                    rf_rd_en_d  = addr_ok && state_q == RD_ADDR;
                    rf_addr_d   = addr_ok ? rx_data[ADDR_W-1:0] : rf_addr_q;
                end
                WR_DATA: begin
                    state_d      = IDLE;
                    rf_wr_data_d = rx_data;
                    rf_wr_en_d   = 1'b1;
                end
                ALU_A: begin
                    state_d = ALU_B;
                    op_a_d  = rx_data;
                end
                ALU_B: begin
                    state_d = ALU_FUN;
                    op_b_d  = rx_data;
                end
                ALU_FUN, NOP_FUN: begin
                    state_d     = IDLE;
                    frame_err_d = !fun_ok;
                    alu_en_d    = fun_ok;
                    alu_fun_d   = fun_ok ? rx_data[3:0] : alu_fun_q;
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef FRAME_TIMEOUT_EN
        else if (tmo) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            alu_fun_q    <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            alu_en_q     <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            alu_fun_q    <= alu_fun_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            alu_en_q     <= alu_en_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rf_wr_en   = rf_wr_en_q;
    assign rf_rd_en   = rf_rd_en_q;
    assign rf_addr    = rf_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign alu_en     = alu_en_q;
    assign alu_fun    = alu_fun_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign frame_err  = frame_err_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// tb_uart_rx_cmd_decoder: scoreboard bench for uart_rx_cmd_decoder
module tb_uart_rx_cmd_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;
    logic       rf_wr_en, rf_rd_en, alu_en, frame_err, busy;
    logic [3:0] rf_addr, alu_fun;
    logic [7:0] rf_wr_data, op_a, op_b;

    typedef struct {
        int          kind;
        int          idx;
        int          lat;
        logic [31:0] exp;
        logic [31:0] m;
    } exp_t;

    exp_t sbq[$];
    int   byte_cyc[256];
    int   nb = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    uart_rx_cmd_decoder #(.TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .par_err(par_err), .stp_err(stp_err), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
        .rf_addr(rf_addr), .rf_wr_data(rf_wr_data), .alu_en(alu_en), .alu_fun(alu_fun),
        .op_a(op_a), .op_b(op_b), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // kind: 0 write, 1 read, 2 alu, 3 frame_err; lat is cycles after the next byte driven
    function automatic void push_exp(input int kind, input logic [3:0] a, input logic [7:0] d,
                                     input logic [3:0] f, input logic [7:0] oa, input logic [7:0] ob,
                                     input int lat);
        exp_t e;
        e.kind = kind;
        e.idx  = nb;
        e.lat  = lat;
        e.exp  = {a, d, f, oa, ob};
        e.m    = kind == 0 ? 32'hFFF0_0000 : kind == 1 ? 32'hF000_0000 :
                 kind == 2 ? 32'h000F_FFFF : 32'h0;
        sbq.push_back(e);
    endfunction

    initial forever begin
        logic [31:0] got;
        int          k;
        exp_t        e;
        @(negedge clk);
        got = {rf_addr, rf_wr_data, alu_fun, op_a, op_b};
        k   = rf_wr_en ? 0 : rf_rd_en ? 1 : alu_en ? 2 : frame_err ? 3 : 4;
        if (k != 4) begin
            checks++;
            if ($countones({rf_wr_en, rf_rd_en, alu_en, frame_err}) > 1) begin
                errors++;
                $display("FAIL exclusivity cyc %0d got %b", cyc, {rf_wr_en, rf_rd_en, alu_en, frame_err});
            end
        end
        if (sbq.size() > 0 && sbq[0].idx < nb && byte_cyc[sbq[0].idx] + sbq[0].lat == cyc) begin
            e = sbq.pop_front();
            checks++;
            if (k !== e.kind || (got & e.m) !== (e.exp & e.m)) begin
                errors++;
                $display("FAIL scoreboard cyc %0d kind got %0d exp %0d fields got %h exp %h",
                         cyc, k, e.kind, got & e.m, e.exp & e.m);
            end
        end else if (k != 4) begin
            checks++;
            errors++;
            $display("FAIL unexpected output cyc %0d kind %0d", cyc, k);
        end
    end

    task automatic put(input logic [7:0] b, input logic p, input logic s);
        @(negedge clk);
        rx_data  = b;
        par_err  = p;
        stp_err  = s;
        rx_valid = 1'b1;
        byte_cyc[nb] = cyc;
        nb++;
    endtask

    task automatic send(input logic [7:0] b, input logic p, input logic s);
        put(b, p, s);
        @(negedge clk);
        rx_valid = 1'b0;
        par_err  = 1'b0;
        stp_err  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rf_wr_en, rf_rd_en, alu_en, frame_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 0000", {rf_wr_en, rf_rd_en, alu_en, frame_err});
        end
        checks++;
        if ({rf_addr, rf_wr_data, alu_fun, op_a, op_b} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {rf_addr, rf_wr_data, alu_fun, op_a, op_b});
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rf_write();
        send(8'hAA, 0, 0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_busy got %b exp 1", busy);
        end
        repeat (14) @(negedge clk);
        send(8'h05, 0, 0);
        repeat (14) @(negedge clk);
        push_exp(0, 4'h5, 8'h3C, 0, 0, 0, 1);
        send(8'h3C, 0, 0);
        checks++;
        if (rf_wr_en !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_strobe_busy got %b%b exp 10", rf_wr_en, busy);
        end
    endtask

    task automatic test_alu();
        send(8'hCC, 0, 0);
        send(8'h12, 0, 0);
        send(8'h34, 0, 0);
        push_exp(2, 0, 0, 4'h3, 8'h12, 8'h34, 1);
        send(8'h03, 0, 0);
        send(8'hDD, 0, 0);
        push_exp(2, 0, 0, 4'h7, 8'h12, 8'h34, 1);
        send(8'h07, 0, 0);
        checks++;
        if (alu_fun !== 4'h7 || op_a !== 8'h12 || op_b !== 8'h34) begin
            errors++;
            $display("FAIL nop_reuse got %h %h %h exp 7 12 34", alu_fun, op_a, op_b);
        end
    endtask

    task automatic test_rd_range();
        send(8'hBB, 0, 0);
        push_exp(3, 0, 0, 0, 0, 0, 1);
        send(8'h1F, 0, 0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_range_busy got %b exp 0", busy);
        end
        send(8'hBB, 0, 0);
        push_exp(1, 4'hF, 0, 0, 0, 0, 1);
        send(8'h0F, 0, 0);
    endtask

    task automatic test_bad_bytes();
        send(8'hAA, 0, 0);
        push_exp(3, 0, 0, 0, 0, 0, 1);
        send(8'h05, 1, 0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL par_abort_busy got %b exp 0", busy);
        end
        push_exp(3, 0, 0, 0, 0, 0, 1);
        send(8'h77, 0, 0);
        send(8'hAA, 0, 1);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stp_idle_busy got %b exp 0", busy);
        end
    endtask

    task automatic test_fun_range();
        send(8'hCC, 0, 0);
        send(8'h55, 0, 0);
        send(8'h66, 0, 0);
        push_exp(3, 0, 0, 0, 0, 0, 1);
        send(8'hF3, 0, 0);
        checks++;
        if (op_a !== 8'h55 || op_b !== 8'h66 || alu_fun !== 4'h7) begin
            errors++;
            $display("FAIL fun_abort_hold got %h %h %h exp 55 66 7", op_a, op_b, alu_fun);
        end
        send(8'hDD, 0, 0);
        push_exp(3, 0, 0, 0, 0, 0, 1);
        send(8'h12, 0, 0);
        send(8'hDD, 0, 0);
        push_exp(2, 0, 0, 4'h2, 8'h55, 8'h66, 1);
        send(8'h02, 0, 0);
    endtask

    task automatic test_back_to_back();
        put(8'hAA, 0, 0);
        put(8'h03, 0, 0);
        push_exp(0, 4'h3, 8'h44, 0, 0, 0, 1);
        put(8'h44, 0, 0);
        put(8'hBB, 0, 0);
        push_exp(1, 4'h2, 0, 0, 0, 0, 1);
        put(8'h02, 0, 0);
        put(8'hCC, 0, 0);
        put(8'h01, 0, 0);
        put(8'h02, 0, 0);
        push_exp(2, 0, 0, 4'h5, 8'h01, 8'h02, 1);
        put(8'h05, 0, 0);
        put(8'hDD, 0, 0);
        push_exp(2, 0, 0, 4'h9, 8'h01, 8'h02, 1);
        put(8'h09, 0, 0);
        push_exp(3, 0, 0, 0, 0, 0, 1);
        put(8'h99, 0, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        send(8'hCC, 0, 0);
        send(8'h12, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({rf_addr, rf_wr_data, alu_fun, op_a, op_b, busy} !== 33'h0) begin
            errors++;
            $display("FAIL mid_reset got %h exp 0", {rf_addr, rf_wr_data, alu_fun, op_a, op_b, busy});
        end
        push_exp(3, 0, 0, 0, 0, 0, 1);
        send(8'h03, 0, 0);
    endtask

`ifdef FRAME_TIMEOUT_EN
    task automatic test_timeout();
        push_exp(3, 0, 0, 0, 0, 0, 21);
        send(8'hAA, 0, 0);
        repeat (25) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_busy got %b exp 0", busy);
        end
        send(8'hAA, 0, 0);
        repeat (18) @(negedge clk);
        put(8'h05, 0, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL expiry_byte_wins busy got %b exp 1", busy);
        end
        push_exp(0, 4'h5, 8'h3C, 0, 0, 0, 1);
        send(8'h3C, 0, 0);
    endtask
`else
    task automatic test_no_timeout();
        send(8'hAA, 0, 0);
        repeat (1500) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_busy got %b exp 1", busy);
        end
        send(8'h05, 0, 0);
        push_exp(0, 4'h5, 8'h3C, 0, 0, 0, 1);
        send(8'h3C, 0, 0);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rf_write();
        test_alu();
        test_rd_range();
        test_bad_bytes();
        test_fun_range();
        test_back_to_back();
        test_mid_reset();
`ifdef FRAME_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (4) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations got %0d exp 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
